// File: rtl/motor_rx_pkg.sv
// motor_rx_pkg
// Shared types and constants for the motor command receiver:
//   - rx_state_t : receiver FSM states
//   - STOP_ALL / M1_STOP / M2_STOP : byte codes for "both stop" and the
//     zero-speed points of motor 1 and motor 2
//   - SPEED_MAX  : largest command magnitude
//   - sat_speed  : clamps a 9-bit signed difference to +/-SPEED_MAX
`timescale 1ns/1ps
package motor_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0]        STOP_ALL  = 8'h00;
    localparam logic [7:0]        M1_STOP   = 8'd64;
    localparam logic [7:0]        M2_STOP   = 8'd192;
    localparam logic signed [6:0] SPEED_MAX = 7'sd63;

    // Motor 2 can produce -64 (byte 0x80); the command range is symmetric,
    // so everything is clamped to +/-63.
    function automatic logic signed [6:0] sat_speed(input logic signed [8:0] diff);
        if (diff > 9'(SPEED_MAX))
            return SPEED_MAX;
        else if (diff < -9'(SPEED_MAX))
            return -SPEED_MAX;
        else
            return diff[6:0];
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 UART receiver: 2-FF input synchroniser, IDLE/START/DATA/STOP FSM and
// baud counter. Bits are sampled at mid-bit, LSB first.
// Ports:
//   CLOCK_50      in   system clock
//   reset         in   asynchronous active-low reset
//   uart_in       in   serial line, idle high, asynchronous
//   byte_data     out  last correctly framed byte
//   byte_valid    out  one-cycle pulse when byte_data updates
//   framing_error out  one-cycle pulse when the stop bit samples low
`timescale 1ns/1ps
module uart_rx_core
    import motor_rx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       uart_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       framing_error
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    rx_state_t        state_reg, state_next;
    logic [1:0]       sync_reg;
    logic             rx_prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       byte_data_reg;
    logic             byte_valid_reg;
    logic             framing_error_reg;

    logic rx_s;
    logic fall_edge;
    logic half_done;
    logic bit_done;
    logic cnt_clear;
    logic shift_en;
    logic load_byte;
    logic frame_err;

    assign rx_s      = sync_reg[1];
    // Edge (not level) detect, so a line stuck low cannot retrigger.
    assign fall_edge = rx_prev_reg & ~rx_s;
    assign half_done = (cnt_reg == CNT_W'(HALF_BIT - 1));
    assign bit_done  = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

    // State register
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (fall_edge) state_next = START;
            START: if (half_done) state_next = rx_s ? IDLE : DATA;
            DATA:  if (bit_done && bit_idx_reg == 3'd7) state_next = STOP;
            STOP:  if (bit_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath controls
    always_comb begin
        cnt_clear = 1'b0;
        shift_en  = 1'b0;
        load_byte = 1'b0;
        frame_err = 1'b0;
        case (state_reg)
            IDLE:  cnt_clear = 1'b1;
            START: cnt_clear = half_done;
            DATA: begin
                cnt_clear = bit_done;
                shift_en  = bit_done;
            end
            STOP: begin
                cnt_clear = bit_done;
                load_byte = bit_done & rx_s;
                frame_err = bit_done & ~rx_s;
            end
            default: cnt_clear = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync_reg          <= 2'b11;
            rx_prev_reg       <= 1'b1;
            cnt_reg           <= '0;
            bit_idx_reg       <= 3'd0;
            shift_reg         <= 8'h00;
            byte_data_reg     <= 8'h00;
            byte_valid_reg    <= 1'b0;
            framing_error_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], uart_in};
            rx_prev_reg <= rx_s;
            cnt_reg     <= cnt_clear ? '0 : cnt_reg + 1'b1;
            if (state_reg == IDLE)
                bit_idx_reg <= 3'd0;
            else if (shift_en)
                bit_idx_reg <= bit_idx_reg + 3'd1;
            if (shift_en)
                shift_reg <= {rx_s, shift_reg[7:1]};
            if (load_byte)
                byte_data_reg <= shift_reg;
            byte_valid_reg    <= load_byte;
            framing_error_reg <= frame_err;
        end
    end

    assign byte_data     = byte_data_reg;
    assign byte_valid    = byte_valid_reg;
    assign framing_error = framing_error_reg;

endmodule

// File: rtl/motor_cmd_rx.sv
// motor_cmd_rx
// Receives the simplified-serial motor protocol and decodes it into two
// signed 7-bit speed commands.
//   0x00       : both motors stop
//   0x01..0x7F : motor 1 = byte - 64
//   0x80..0xFF : motor 2 = byte - 192 (clamped to -63)
// Optional link watchdog, compiled in with MOTOR_CMD_RX_WATCHDOG_EN: stops
// both motors if no byte arrives for TIMEOUT_CYCLES clocks.
// Ports:
//   CLOCK_50      in   system clock
//   reset         in   asynchronous active-low reset
//   uart_in       in   serial line, idle high
//   byte_data     out  last correctly framed byte
//   byte_valid    out  pulse when byte_data updates
//   framing_error out  pulse on a low stop bit
//   motor1_speed  out  signed motor-1 command
//   motor2_speed  out  signed motor-2 command
//   cmd_update    out  pulse when a speed is rewritten
//   link_timeout  out  high while the watchdog holds the motors stopped
`timescale 1ns/1ps
module motor_cmd_rx
    import motor_rx_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BAUD           = 9600,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       uart_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       framing_error,
    output logic [6:0] motor1_speed,
    output logic [6:0] motor2_speed,
    output logic       cmd_update,
    output logic       link_timeout
);

    logic signed [6:0] motor1_speed_reg;
    logic signed [6:0] motor2_speed_reg;
    logic              cmd_update_reg;
    logic signed [8:0] m1_diff;
    logic signed [8:0] m2_diff;
    logic              wd_expire;

    uart_rx_core #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .uart_in       (uart_in),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .framing_error (framing_error)
    );

    assign m1_diff = $signed({1'b0, byte_data}) - $signed({1'b0, M1_STOP});
    assign m2_diff = $signed({1'b0, byte_data}) - $signed({1'b0, M2_STOP});

`ifdef MOTOR_CMD_RX_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            link_timeout_reg;

    // Fires once; a byte in the same cycle takes priority.
    assign wd_expire = (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) &&
                       !link_timeout_reg && !byte_valid;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg       <= '0;
            link_timeout_reg <= 1'b0;
        end else if (byte_valid) begin
            wd_cnt_reg       <= '0;
            link_timeout_reg <= 1'b0;
        end else if (wd_expire) begin
            link_timeout_reg <= 1'b1;
        end else if (!link_timeout_reg) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end

    assign link_timeout = link_timeout_reg;
`else
    assign wd_expire    = 1'b0;
    assign link_timeout = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            motor1_speed_reg <= '0;
            motor2_speed_reg <= '0;
            cmd_update_reg   <= 1'b0;
        end else begin
            cmd_update_reg <= 1'b0;
            if (byte_valid) begin
                cmd_update_reg <= 1'b1;
                if (byte_data == STOP_ALL) begin
                    motor1_speed_reg <= '0;
                    motor2_speed_reg <= '0;
                end else if (!byte_data[7]) begin
                    motor1_speed_reg <= sat_speed(m1_diff);
                end else begin
                    motor2_speed_reg <= sat_speed(m2_diff);
                end
            end else if (wd_expire) begin
                motor1_speed_reg <= '0;
                motor2_speed_reg <= '0;
                cmd_update_reg   <= 1'b1;
            end
        end
    end

    assign motor1_speed = motor1_speed_reg;
    assign motor2_speed = motor2_speed_reg;
    assign cmd_update   = cmd_update_reg;

endmodule

// File: tb/tb_motor_cmd_rx.sv
// tb_motor_cmd_rx
// Directed bench for motor_cmd_rx at a scaled baud rate (32 clocks per bit)
// so that each frame is short. Watchdog checks follow the same build macro
// as the RTL (MOTOR_CMD_RX_WATCHDOG_EN) with TIMEOUT_CYCLES = 1000.
`timescale 1ns/1ps
module tb_motor_cmd_rx;

    localparam int CPB = 32;

    logic       clk;
    logic       rst_n;
    logic       uart_in;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       framing_error;
    logic [6:0] motor1_speed;
    logic [6:0] motor2_speed;
    logic       cmd_update;
    logic       link_timeout;

    int checks = 0;
    int errors = 0;

    int bv_count = 0;
    int fe_count = 0;
    int cu_count = 0;
    int cu_lat_ok = 0;
    int both_count = 0;
    logic prev_bv = 1'b0;
    logic [7:0] last_byte = 8'h00;

    motor_cmd_rx #(
        .CLK_HZ         (CPB * 10),
        .BAUD           (10),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (rst_n),
        .uart_in       (uart_in),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .framing_error (framing_error),
        .motor1_speed  (motor1_speed),
        .motor2_speed  (motor2_speed),
        .cmd_update    (cmd_update),
        .link_timeout  (link_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (byte_valid) begin
            bv_count  <= bv_count + 1;
            last_byte <= byte_data;
        end
        if (framing_error) fe_count <= fe_count + 1;
        if (byte_valid && framing_error) both_count <= both_count + 1;
        if (cmd_update) begin
            cu_count <= cu_count + 1;
            if (prev_bv) cu_lat_ok <= cu_lat_ok + 1;
        end
        prev_bv <= byte_valid;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 uart_in = b;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1 uart_in = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        uart_in = 1'b1;
        rst_n   = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset byte_data", byte_data, 0);
        check("reset byte_valid", byte_valid, 0);
        check("reset framing_error", framing_error, 0);
        check("reset motor1", $signed(motor1_speed), 0);
        check("reset motor2", $signed(motor2_speed), 0);
        check("reset cmd_update", cmd_update, 0);
        check("reset link_timeout", link_timeout, 0);
        #1 rst_n = 1'b1;
        idle(10);

        // 0x7F -> motor1 +63
        send_byte(8'h7F, 1'b1);
        idle(CPB);
        check("7F bv count", bv_count, 1);
        check("7F byte_data", byte_data, 8'h7F);
        check("7F last byte", last_byte, 8'h7F);
        check("7F motor1", $signed(motor1_speed), 63);
        check("7F motor2", $signed(motor2_speed), 0);
        check("7F cu count", cu_count, 1);
        $display("txn 7F: m1=%0d m2=%0d", $signed(motor1_speed), $signed(motor2_speed));

        // Back-to-back 0x01, 0xC0
        send_byte(8'h01, 1'b1);
        send_byte(8'hC0, 1'b1);
        idle(CPB);
        check("b2b bv count", bv_count, 3);
        check("b2b last byte", last_byte, 8'hC0);
        check("b2b motor1", $signed(motor1_speed), -63);
        check("b2b motor2", $signed(motor2_speed), 0);
        check("b2b cu count", cu_count, 3);
        $display("txn 01,C0: m1=%0d m2=%0d", $signed(motor1_speed), $signed(motor2_speed));

        // 0x80 saturates, then 0x00 stops both
        send_byte(8'hFF, 1'b1);
        idle(CPB);
        check("FF motor2", $signed(motor2_speed), 63);
        send_byte(8'h80, 1'b1);
        idle(CPB);
        check("80 motor2 sat", $signed(motor2_speed), -63);
        check("80 motor1 held", $signed(motor1_speed), -63);
        $display("txn 80: m1=%0d m2=%0d", $signed(motor1_speed), $signed(motor2_speed));
        send_byte(8'h00, 1'b1);
        idle(CPB);
        check("00 motor1", $signed(motor1_speed), 0);
        check("00 motor2", $signed(motor2_speed), 0);
        check("00 cu count", cu_count, 6);
        $display("txn 00: m1=%0d m2=%0d", $signed(motor1_speed), $signed(motor2_speed));

        // Short low glitch, well under half a bit
        @(posedge clk);
        #1 uart_in = 1'b0;
        repeat (6) @(posedge clk);
        idle(2 * CPB);
        check("glitch bv count", bv_count, 6);
        check("glitch fe count", fe_count, 0);
        $display("txn glitch: bv=%0d fe=%0d", bv_count, fe_count);

        // 0x55 with low stop bit
        send_byte(8'h55, 1'b0);
        idle(CPB);
        check("ferr fe count", fe_count, 1);
        check("ferr bv count", bv_count, 6);
        check("ferr byte_data", byte_data, 8'h00);
        check("ferr motor1", $signed(motor1_speed), 0);
        check("ferr motor2", $signed(motor2_speed), 0);
        $display("txn 55/stop-low: fe=%0d byte=%02h", fe_count, byte_data);

        // 0x70 then silence
        send_byte(8'h70, 1'b1);
        idle(4);
        check("70 motor1", $signed(motor1_speed), 48);
        check("70 link_timeout", link_timeout, 0);
        idle(1100);
`ifdef MOTOR_CMD_RX_WATCHDOG_EN
        check("wd motor1", $signed(motor1_speed), 0);
        check("wd link_timeout", link_timeout, 1);
        check("wd cu count", cu_count, 8);
`else
        check("hold motor1", $signed(motor1_speed), 48);
        check("hold link_timeout", link_timeout, 0);
        check("hold cu count", cu_count, 7);
`endif
        $display("txn 70+silence: m1=%0d lt=%0d", $signed(motor1_speed), link_timeout);

        send_byte(8'h50, 1'b1);
        idle(4);
        check("50 motor1", $signed(motor1_speed), 16);
        check("50 link_timeout", link_timeout, 0);
        $display("txn 50: m1=%0d lt=%0d", $signed(motor1_speed), link_timeout);

        // Reset in the middle of a 0xAA frame
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst byte_data", byte_data, 0);
        check("midrst motor1", $signed(motor1_speed), 0);
        check("midrst link_timeout", link_timeout, 0);
        uart_in = 1'b1;
        #1 rst_n = 1'b1;
        idle(12 * CPB);
        check("midrst bv count", bv_count, 8);
        check("midrst fe count", fe_count, 1);
        $display("txn midrst: bv=%0d fe=%0d", bv_count, fe_count);

        send_byte(8'hC5, 1'b1);
        idle(CPB);
        check("C5 byte_data", byte_data, 8'hC5);
        check("C5 motor2", $signed(motor2_speed), 5);
        $display("txn C5: m2=%0d", $signed(motor2_speed));

        check("bv/fe exclusive", both_count, 0);
`ifdef MOTOR_CMD_RX_WATCHDOG_EN
        check("cu latency", cu_lat_ok, cu_count - 1);
`else
        check("cu latency", cu_lat_ok, cu_count);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
